// File: rtl/police_siren_if.sv
`default_nettype none
// =============================================================================
// Module   : police_siren_if
// Brief    : Output bundle of the police siren: speaker pin plus optional
//            sweep status (present when POLICE_STATUS_EN is defined).
// Revision : 1.0 - initial release
// =============================================================================
interface police_siren_if #(
    parameter int DW = 16
);
    logic          speaker;
`ifdef POLICE_STATUS_EN
    logic          sweep_up;
    logic [DW-1:0] half_period;
`endif

`ifdef POLICE_STATUS_EN
    modport master (output speaker, output sweep_up, output half_period);
    modport slave  (input  speaker, input  sweep_up, input  half_period);
`else
    modport master (output speaker);
    modport slave  (input  speaker);
`endif
endinterface
`default_nettype wire

// File: rtl/police_siren.sv
`default_nettype none
// =============================================================================
// Module   : police_siren
// Brief    : Wailing siren square-wave generator; pitch sweeps linearly up and
//            down. Optional status outputs under macro POLICE_STATUS_EN.
// Revision : 1.0 - initial release
// =============================================================================
module police_siren #(
    parameter int TONE_W = 26,
    parameter int RAMP_W = 7,
    parameter int SHIFT  = 7
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    police_siren_if.master bus
);
    localparam int DW = 2 + RAMP_W + SHIFT;

    // Divider with ramp all ones, i.e. the value D takes while tone is 0.
    localparam logic [DW-1:0] c_div_rst = DW'({2'b01, {RAMP_W{1'b1}}}) << SHIFT;

    logic [TONE_W-1:0] r_tone;
    logic [DW-1:0]     r_count;
    logic              r_speaker;

    logic              w_msb;
    logic [RAMP_W-1:0] w_mid;
    logic [RAMP_W-1:0] w_ramp;
    logic [DW-1:0]     w_div;

    // Inverting on the falling half makes the wrap points continuous (triangle).
    assign w_msb  = r_tone[TONE_W-1];
    assign w_mid  = r_tone[TONE_W-2 -: RAMP_W];
    assign w_ramp = w_msb ? w_mid : ~w_mid;
    assign w_div  = DW'({2'b01, w_ramp}) << SHIFT;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tone    <= '0;
            r_count   <= c_div_rst;
            r_speaker <= 1'b0;
        end else begin
            r_tone <= r_tone + 1'b1;
            if (r_count == '0) begin
                r_count   <= w_div;
                r_speaker <= ~r_speaker;
            end else begin
                r_count   <= r_count - 1'b1;
            end
        end
    end

    assign bus.speaker = r_speaker;

`ifdef POLICE_STATUS_EN
    assign bus.sweep_up    = w_msb;
    assign bus.half_period = w_div;
`endif

endmodule
`default_nettype wire

// File: tb/tb_police_siren.sv
`default_nettype none
// =============================================================================
// Module   : tb_police_siren
// Brief    : Self-checking bench for police_siren: a slow instance (TONE_W=12,
//            default ramp/shift) and a fast instance (TONE_W=10, RAMP_W=4,
//            SHIFT=2), each compared every cycle against a toggle-time model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_police_siren;
    localparam int S_TW = 12, S_RW = 7, S_SH = 7, S_DW = 16;
    localparam int F_TW = 10, F_RW = 4, F_SH = 2, F_DW = 8;
    localparam int S_DMAX = 32640, S_DMIN = 16384;
    localparam int F_DMAX = 124,   F_DMIN = 64;

    logic clk;
    logic rst_n_s;
    logic rst_n_f;
    bit   run;

    int n_chk = 0;
    int n_err = 0;

    police_siren_if #(.DW(S_DW)) bus_s ();
    police_siren_if #(.DW(F_DW)) bus_f ();

    police_siren #(.TONE_W(S_TW), .RAMP_W(S_RW), .SHIFT(S_SH)) u_slow (
        .clk   (clk),
        .rst_n (rst_n_s),
        .bus   (bus_s.master)
    );

    police_siren #(.TONE_W(F_TW), .RAMP_W(F_RW), .SHIFT(F_SH)) u_fast (
        .clk   (clk),
        .rst_n (rst_n_f),
        .bus   (bus_f.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Half-period divider for a given tone value, from the sweep rules.
    function automatic int d_of(input int t, input int tw, input int rw, input int sh);
        int msb, mid, ramp;
        msb  = (t >> (tw - 1)) & 1;
        mid  = (t >> (tw - 1 - rw)) & ((1 << rw) - 1);
        ramp = (msb != 0) ? mid : ((1 << rw) - 1 - mid);
        return (1 << (rw + sh)) + ramp * (1 << sh);
    endfunction

    // Event model: k = edges since reset (equals tone), nx = edge of next toggle.
    int ks = 0, nxs = 0, togm_s = 0;
    bit spkm_s = 1'b0;
    int kf = 0, nxf = 0, togm_f = 0;
    bit spkm_f = 1'b0;

    always @(posedge clk) begin
        if (!rst_n_s) begin
            ks     <= 0;
            nxs    <= S_DMAX + 1;
            spkm_s <= 1'b0;
            togm_s <= 0;
        end else begin
            ks <= ks + 1;
            if (ks + 1 == nxs) begin
                spkm_s <= ~spkm_s;
                togm_s <= togm_s + 1;
                nxs    <= ks + 1 + d_of(ks % (1 << S_TW), S_TW, S_RW, S_SH) + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst_n_f) begin
            kf     <= 0;
            nxf    <= F_DMAX + 1;
            spkm_f <= 1'b0;
        end else begin
            kf <= kf + 1;
            if (kf + 1 == nxf) begin
                spkm_f <= ~spkm_f;
                togm_f <= togm_f + 1;
                nxf    <= kf + 1 + d_of(kf % (1 << F_TW), F_TW, F_RW, F_SH) + 1;
            end
        end
    end

    // Per-cycle monitor: model match, half-period range, toggle counting.
    int  togd_s = 0, togd_f = 0;
    int  cyc_s = 0, cyc_f = 0;
    bit  have_s = 1'b0, have_f = 1'b0;
    logic prev_s = 1'b0, prev_f = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (run) begin
                chk("s_speaker_vs_model", bus_s.speaker, spkm_s);
                chk("f_speaker_vs_model", bus_f.speaker, spkm_f);
`ifdef POLICE_STATUS_EN
                chk("s_half_period", bus_s.half_period, d_of(ks % (1 << S_TW), S_TW, S_RW, S_SH));
                chk("s_sweep_up", bus_s.sweep_up, ((ks % (1 << S_TW)) >= (1 << (S_TW - 1))) ? 1 : 0);
                chk("f_half_period", bus_f.half_period, d_of(kf % (1 << F_TW), F_TW, F_RW, F_SH));
                chk("f_sweep_up", bus_f.sweep_up, ((kf % (1 << F_TW)) >= (1 << (F_TW - 1))) ? 1 : 0);
`endif
                cyc_s++;
                if (ks == 0) begin
                    have_s = 1'b0;
                end else if (bus_s.speaker !== prev_s) begin
                    togd_s++;
                    if (have_s)
                        chk("s_hp_in_range", (cyc_s >= S_DMIN + 1 && cyc_s <= S_DMAX + 1) ? 1 : 0, 1);
                    have_s = 1'b1;
                    cyc_s  = 0;
                end
                cyc_f++;
                if (kf == 0) begin
                    have_f = 1'b0;
                end else if (bus_f.speaker !== prev_f) begin
                    togd_f++;
                    if (have_f)
                        chk("f_hp_in_range", (cyc_f >= F_DMIN + 1 && cyc_f <= F_DMAX + 1) ? 1 : 0, 1);
                    have_f = 1'b1;
                    cyc_f  = 0;
                end
                prev_s = bus_s.speaker;
                prev_f = bus_f.speaker;
            end
        end
    end

    typedef struct {
        string nm;
        bit    rst_n;
        int    edges;
        bit    exp_spk;
        int    exp_cnt;
    } vec_t;

    vec_t tbl[5];

    task automatic slow_seq();
        int d1, d2;
        d1 = d_of(S_DMAX % (1 << S_TW), S_TW, S_RW, S_SH);
        d2 = d_of((S_DMAX + 1 + d1) % (1 << S_TW), S_TW, S_RW, S_SH);
        tbl[0] = '{"s_reset",    1'b0, 5,      1'b0, S_DMAX};
        tbl[1] = '{"s_pre_rise", 1'b1, S_DMAX, 1'b0, 0};
        tbl[2] = '{"s_rise",     1'b1, 1,      1'b1, d1};
        tbl[3] = '{"s_pre_fall", 1'b1, d1,     1'b1, 0};
        tbl[4] = '{"s_fall",     1'b1, 1,      1'b0, d2};
        for (int i = 0; i < 5; i++) begin
            rst_n_s = tbl[i].rst_n;
            repeat (tbl[i].edges) @(negedge clk);
            chk({tbl[i].nm, "_speaker"}, bus_s.speaker, tbl[i].exp_spk);
            chk({tbl[i].nm, "_counter"}, u_slow.r_count, tbl[i].exp_cnt);
        end
    endtask

    task automatic fast_seq();
        int n;
        int k0;
        rst_n_f = 1'b1;
        n = 0;
        while (bus_f.speaker !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("f_first_rise_edge", n, F_DMAX + 1);

        repeat (10) @(negedge clk);
        chk("f_mid_high", bus_f.speaker, 1);
        rst_n_f = 1'b0;
        @(negedge clk);
        chk("f_midrst_speaker", bus_f.speaker, 0);
        chk("f_midrst_counter", u_fast.r_count, F_DMAX);
        chk("f_midrst_tone", u_fast.r_tone, 0);
        rst_n_f = 1'b1;
        n = 0;
        while (bus_f.speaker !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("f_restart_rise_edge", n, F_DMAX + 1);

        // A low pulse entirely between edges must not be seen.
        k0 = kf;
        #1 rst_n_f = 1'b0;
        #1 rst_n_f = 1'b1;
        @(negedge clk);
        chk("f_glitch_tone", u_fast.r_tone, (k0 + 1) % (1 << F_TW));

        repeat (4000) begin
            rst_n_f = ($urandom_range(0, 199) != 0);
            @(negedge clk);
        end
        rst_n_f = 1'b1;
    endtask

    initial begin
        run     = 1'b0;
        rst_n_s = 1'b0;
        rst_n_f = 1'b0;
        repeat (5) @(negedge clk);
        run = 1'b1;
        chk("f_reset_speaker", bus_f.speaker, 0);
        chk("f_reset_counter", u_fast.r_count, F_DMAX);
        fork
            slow_seq();
            fast_seq();
        join
        repeat (3000) @(negedge clk);
        chk("s_toggle_count", togd_s, togm_s);
        chk("f_toggle_count", togd_f, togm_f);
        chk("f_not_stuck", (togd_f > 100) ? 1 : 0, 1);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
`default_nettype wire
